sdram_bank_sequencer: RTL and testbench

Per-bank command sequencer that drives the SDRAM enable generator's control inputs (LdState, TimerLd, TimerCount, RwState). Accepts one read/write request at a time from the bus interface and walks the bank through precharge, activate, read/write command and burst phases with programmable timer delays. Tracks the open row so that row hits skip precharge/activate.

---
 rtl/sdram_bank_sequencer.sv | 126 ++++++++++++
 tb/tb_sdram_bank_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_bank_sequencer.sv
// rtl/sdram_bank_sequencer.sv - per-bank PRE/ACT/RD/WR/BURST sequencer with open-row tracking
// Drives the enable generator's phase code, timer load pulse and down-counter.
module sdram_bank_sequencer #(
  parameter int T_RP      = 2,
  parameter int T_RCD     = 2,
  parameter int T_CAS     = 2,
  parameter int BURST_LEN = 4,
  parameter int ROW_W     = 12
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ReqValid,
  output logic             ReqReady,
  input  logic             ReqRw,
  input  logic [ROW_W-1:0] ReqRow,
  input  logic             BusySignal,
  output logic [2:0]       LdState,
  output logic             TimerLd,
  output logic [7:0]       TimerCount,
  output logic             RwState,
  output logic             Done,
  output logic             RowOpen
);

  typedef enum logic [2:0] {
    PH_PRE   = 3'b000,
    PH_ACT   = 3'b001,
    PH_WR    = 3'b010,
    PH_RD    = 3'b011,
    PH_BURST = 3'b100,
    PH_IDLE  = 3'b111
  } phase_e;

  phase_e           state_q;
  phase_e           first_phase_d;
  phase_e           next_phase_d;
  logic [7:0]       count_q;
  logic             tld_q;
  logic             rw_q;
  logic             done_q;
  logic             row_open_q;
  logic [ROW_W-1:0] open_row_q;
  logic [ROW_W-1:0] req_row_q;
  logic             row_hit;

  function automatic logic [7:0] load_of(input phase_e ph);
    case (ph)
      PH_PRE:        load_of = 8'(T_RP);
      PH_ACT:        load_of = 8'(T_RCD);
      PH_WR, PH_RD:  load_of = 8'(T_CAS);
      PH_BURST:      load_of = 8'(BURST_LEN);
      default:       load_of = 8'd0;
    endcase
  endfunction

  always_comb begin
    row_hit       = row_open_q && (ReqRow == open_row_q);
    first_phase_d = PH_ACT;
    if (row_hit)
      first_phase_d = ReqRw ? PH_WR : PH_RD;
    else if (row_open_q)
      first_phase_d = PH_PRE;

    next_phase_d = PH_IDLE;
    case (state_q)
      PH_PRE:        next_phase_d = PH_ACT;
      PH_ACT:        next_phase_d = rw_q ? PH_WR : PH_RD;
      PH_WR, PH_RD:  next_phase_d = PH_BURST;
      default:       next_phase_d = PH_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= PH_IDLE;
      tld_q      <= 1'b0;
      count_q    <= 8'd0;
      rw_q       <= 1'b0;
      done_q     <= 1'b0;
      row_open_q <= 1'b0;
      open_row_q <= '0;
      req_row_q  <= '0;
    end else begin
      tld_q  <= 1'b0;
      done_q <= 1'b0;
      if (state_q == PH_IDLE) begin
        if (ReqValid) begin
          rw_q      <= ReqRw;
          req_row_q <= ReqRow;
          state_q   <= first_phase_d;
          tld_q     <= 1'b1;
          count_q   <= load_of(first_phase_d);
          if (first_phase_d == PH_ACT) begin
            row_open_q <= 1'b1;
            open_row_q <= ReqRow;
          end
        end
      end else if (!BusySignal) begin
        if (count_q != 8'd0) begin
          count_q <= count_q - 8'd1;
        end else if (next_phase_d == PH_IDLE) begin
          state_q <= PH_IDLE;
          done_q  <= 1'b1;
        end else begin
          state_q <= next_phase_d;
          tld_q   <= 1'b1;
          count_q <= load_of(next_phase_d);
          // PRE exit closes the row and ACT entry reopens it on the same edge
          if (next_phase_d == PH_ACT) begin
            row_open_q <= 1'b1;
            open_row_q <= req_row_q;
          end
        end
      end
    end
  end

  assign ReqReady   = (state_q == PH_IDLE);
  assign LdState    = state_q;
  assign TimerLd    = tld_q;
  assign TimerCount = count_q;
  assign RwState    = rw_q;
  assign Done       = done_q;
  assign RowOpen    = row_open_q;

endmodule

// File: tb/tb_sdram_bank_sequencer.sv
// tb/tb_sdram_bank_sequencer.sv - self-checking bench with a phase-queue reference model
// The model expands each request into its list of (phase, count) cycles and replays it.
module tb_sdram_bank_sequencer;

  localparam int T_RP      = 2;
  localparam int T_RCD     = 2;
  localparam int T_CAS     = 2;
  localparam int BURST_LEN = 4;
  localparam int ROW_W     = 12;

  logic             Clk = 1'b0;
  logic             Reset;
  logic             ReqValid;
  logic             ReqReady;
  logic             ReqRw;
  logic [ROW_W-1:0] ReqRow;
  logic             BusySignal;
  logic [2:0]       LdState;
  logic             TimerLd;
  logic [7:0]       TimerCount;
  logic             RwState;
  logic             Done;
  logic             RowOpen;

  sdram_bank_sequencer #(
    .T_RP(T_RP), .T_RCD(T_RCD), .T_CAS(T_CAS), .BURST_LEN(BURST_LEN), .ROW_W(ROW_W)
  ) dut (
    .Clk(Clk), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqRw(ReqRw), .ReqRow(ReqRow), .BusySignal(BusySignal), .LdState(LdState),
    .TimerLd(TimerLd), .TimerCount(TimerCount), .RwState(RwState), .Done(Done),
    .RowOpen(RowOpen)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0] ph;
    int         cnt;
    bit         tld;
  } ent_t;

  ent_t             q[$];
  bit               done_m;
  bit               ro_m;
  bit               rw_m;
  logic [ROW_W-1:0] orow_m;
  int               checks = 0;
  int               errors = 0;
  int               cyc = 0;
  int               last_done_cyc = -1000;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", tag, $time, act, exp);
    end
  endtask

  function automatic int load_of(input logic [2:0] ph);
    case (ph)
      3'b000:         return T_RP;
      3'b001:         return T_RCD;
      3'b010, 3'b011: return T_CAS;
      default:        return BURST_LEN;
    endcase
  endfunction

  function automatic void push_phase(input logic [2:0] ph);
    ent_t e;
    for (int c = load_of(ph); c >= 0; c--) begin
      e.ph  = ph;
      e.cnt = c;
      e.tld = (c == load_of(ph));
      q.push_back(e);
    end
  endfunction

  function automatic void model_reset();
    q.delete();
    done_m = 0;
    ro_m   = 0;
    rw_m   = 0;
    orow_m = '0;
  endfunction

  function automatic void model_step(input bit v, input bit rw, input logic [ROW_W-1:0] row,
                                     input bit busy);
    ent_t e;
    done_m = 0;
    if (q.size() > 0) begin
      if (busy) begin
        e     = q[0];
        e.tld = 0;
        q[0]  = e;
      end else begin
        void'(q.pop_front());
        if (q.size() == 0) done_m = 1;
      end
    end else if (v) begin
      if (ro_m && row == orow_m) begin
        push_phase(rw ? 3'b010 : 3'b011);
      end else begin
        if (ro_m) push_phase(3'b000);
        push_phase(3'b001);
        push_phase(rw ? 3'b010 : 3'b011);
      end
      push_phase(3'b100);
      ro_m   = 1;
      orow_m = row;
      rw_m   = rw;
    end
  endfunction

  task automatic cycle_check();
    bit active;
    active = (q.size() > 0);
    chk("ld_state", LdState, active ? q[0].ph : 3'b111);
    chk("timer_ld", TimerLd, active ? q[0].tld : 1'b0);
    chk("timer_count", TimerCount, active ? q[0].cnt : 0);
    chk("rw_state", RwState, rw_m);
    chk("done", Done, done_m);
    chk("row_open", RowOpen, active ? 1'b1 : ro_m);
    chk("req_ready", ReqReady, !active);
    if (Done === 1'b1) last_done_cyc = cyc;
  endtask

  task automatic step(input bit v, input bit rw, input logic [ROW_W-1:0] row, input bit busy);
    @(negedge Clk);
    cycle_check();
    Reset      = 1'b0;
    ReqValid   = v;
    ReqRw      = rw;
    ReqRow     = row;
    BusySignal = busy;
    model_step(v, rw, row, busy);
    @(posedge Clk);
    cyc++;
  endtask

  // bph 3'b110 selects random busy; otherwise busy is raised for blen cycles at (bph, bcnt)
  task automatic run_req(input bit rw, input logic [ROW_W-1:0] row, input logic [2:0] bph,
                         input int bcnt, input int blen, output int acc, output int e);
    int nbusy = 0;
    int left  = 0;
    bit inj   = 0;
    bit busy;
    bit hit;
    bit conf;
    hit  = ro_m && (row == orow_m);
    conf = ro_m && !hit;
    e    = 1 + (T_CAS + 1) + (BURST_LEN + 1) + (hit ? 0 : T_RCD + 1) + (conf ? T_RP + 1 : 0);
    acc  = cyc;
    step(1'b1, rw, row, 1'b0);
    for (int k = 0; k < 300 && q.size() > 0; k++) begin
      busy = 0;
      if (bph == 3'b110) begin
        busy = ($urandom_range(0, 3) == 0);
      end else begin
        if (!inj && q[0].ph == bph && q[0].cnt == bcnt) begin
          inj  = 1;
          left = blen;
        end
        if (left > 0) begin
          busy = 1;
          left--;
        end
      end
      if (busy) nbusy++;
      step(1'b0, 1'b0, '0, busy);
    end
    if (q.size() > 0) chk("req_timeout", q.size(), 0);
    e += nbusy;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  initial begin
    int acc;
    int e;
    int pacc;
    int pe;
    bit pend;
    Reset      = 1'b1;
    ReqValid   = 1'b0;
    ReqRw      = 1'b0;
    ReqRow     = '0;
    BusySignal = 1'b0;
    model_reset();
    @(posedge Clk);
    @(posedge Clk);

    run_req(1'b1, 12'h005, 3'b101, 0, 0, acc, e);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("wr_closed_lat", last_done_cyc - acc, 12);

    run_req(1'b0, 12'h005, 3'b101, 0, 0, acc, e);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("rd_hit_lat", last_done_cyc - acc, 9);

    run_req(1'b1, 12'h007, 3'b101, 0, 0, acc, e);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("wr_conflict_lat", last_done_cyc - acc, 15);

    run_req(1'b1, 12'h007, 3'b100, 2, 3, acc, e);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("burst_busy_lat", last_done_cyc - acc, 12);

    run_req(1'b1, 12'h100, 3'b001, 0, 2, acc, e);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("act_busy_lat", last_done_cyc - acc, 17);

    step(1'b1, 1'b1, 12'h100, 1'b0);
    step(1'b0, 1'b0, '0, 1'b0);
    @(negedge Clk);
    cycle_check();
    Reset = 1'b1;
    #1;
    chk("rst_ld_state", LdState, 3'b111);
    chk("rst_timer_ld", TimerLd, 1'b0);
    chk("rst_timer_count", TimerCount, 8'd0);
    chk("rst_row_open", RowOpen, 1'b0);
    chk("rst_done", Done, 1'b0);
    chk("rst_rw_state", RwState, 1'b0);
    model_reset();
    @(posedge Clk);
    cyc++;

    run_req(1'b1, 12'h005, 3'b101, 0, 0, acc, e);
    step(1'b0, 1'b0, '0, 1'b0);
    chk("after_rst_lat", last_done_cyc - acc, 12);

    pend = 0;
    pacc = 0;
    pe   = 0;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 0) step(1'b0, 1'b0, '0, 1'b0);
      run_req(1'($urandom_range(0, 1)), ROW_W'($urandom_range(0, 3)), 3'b110, 0, 0, acc, e);
      if (pend) chk("rand_lat", last_done_cyc - pacc, pe);
      pacc = acc;
      pe   = e;
      pend = 1;
    end
    step(1'b0, 1'b0, '0, 1'b0);
    chk("rand_lat", last_done_cyc - pacc, pe);
    step(1'b0, 1'b0, '0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
